// File: rtl/mux8_rr_sched.sv
// rtl/mux8_rr_sched.sv - round-robin 8-way select with registered valid/ready output
// Optional MUX8_SCHED_PRIO_EN adds hi_prio to restrict the search to high-priority requesters.
module mux8_rr_sched #(
  parameter int WIDTH = 8,
  parameter int NREQ  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
`ifdef MUX8_SCHED_PRIO_EN
  input  logic [NREQ-1:0]       hi_prio,
`endif
  output logic [NREQ-1:0]       gnt,
  output logic [2:0]            sel,
  output logic [WIDTH-1:0]      dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy
);

  typedef enum logic {IDLE, FULL} state_t;

  state_t           state_q, state_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [NREQ-1:0]  cand;
  logic [2:0]       win;
  logic [2:0]       idx;
  logic             found;
  logic             load;

  // Search starts at ptr and wraps; the first candidate found wins.
  always_comb begin
    cand = req;
`ifdef MUX8_SCHED_PRIO_EN
    if ((req & hi_prio) != '0) cand = req & hi_prio;
`endif
    win   = ptr_q;
    idx   = ptr_q;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = ptr_q + 3'(i);
      if (!found && cand[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  // Reset suppresses the accept strobe so no requester believes it was served.
  assign load = !rst && found && (state_q == IDLE || dout_ready);
  assign gnt  = load ? (NREQ'(1) << win) : '0;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    dout_d  = dout_q;
    if (load) begin
      dout_d  = din[win*WIDTH +: WIDTH];
      sel_d   = win;
      ptr_d   = win + 3'd1;
      state_d = FULL;
    end else if (state_q == FULL && dout_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 3'd0;
      sel_q   <= 3'd0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      dout_q  <= dout_d;
    end
  end

  assign sel        = sel_q;
  assign dout       = dout_q;
  assign dout_valid = (state_q == FULL);
  assign busy       = dout_valid;

endmodule

// File: tb/tb_mux8_rr_sched.sv
// tb/tb_mux8_rr_sched.sv - table-driven and scoreboard bench for mux8_rr_sched
module tb_mux8_rr_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  req;
  logic [63:0] din;
  logic [7:0]  gnt;
  logic [2:0]  sel;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        busy;
`ifdef MUX8_SCHED_PRIO_EN
  logic [7:0]  hi_prio;
`endif

  always #5 clk = ~clk;

  mux8_rr_sched #(.WIDTH(8), .NREQ(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .din        (din),
`ifdef MUX8_SCHED_PRIO_EN
    .hi_prio    (hi_prio),
`endif
    .gnt        (gnt),
    .sel        (sel),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy)
  );

  typedef struct packed {
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic [7:0] gnt;
    logic       valid;
  } vec_t;

  typedef struct packed {
    logic [7:0] w;
    logic [2:0] s;
  } exp_t;

  vec_t tbl [24];
  exp_t sb_q[$];
  exp_t cur;
  logic have_cur = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v);
    int gi;
    @(negedge clk);
    rst        = v.rst;
    req        = v.req;
    dout_ready = v.rdy;
    #1;
    check("gnt", gnt, v.gnt);
    check("dout_valid", {7'd0, dout_valid}, {7'd0, v.valid});
    check("busy", {7'd0, busy}, {7'd0, v.valid});
    if (sb_q.size() > 0) begin
      cur      = sb_q.pop_front();
      have_cur = 1'b1;
    end
    if (have_cur) begin
      check("dout", dout, cur.w);
      check("sel", {5'd0, sel}, {5'd0, cur.s});
    end
    if (v.rst) begin
      sb_q.delete();
      sb_q.push_back('{w: 8'h00, s: 3'd0});
    end else if (v.gnt != 8'h00) begin
      gi = 0;
      for (int i = 0; i < 8; i++) if (v.gnt[i]) gi = i;
      sb_q.push_back('{w: din[gi*8 +: 8], s: 3'(gi)});
    end
  endtask

  initial begin
    tbl = '{
      '{1'b1, 8'hFF, 1'b1, 8'h00, 1'b0},
      '{1'b0, 8'hFF, 1'b1, 8'h01, 1'b0},
      '{1'b0, 8'hFF, 1'b1, 8'h02, 1'b1},
      '{1'b0, 8'hFF, 1'b1, 8'h04, 1'b1},
      '{1'b0, 8'hFF, 1'b1, 8'h08, 1'b1},
      '{1'b0, 8'hFF, 1'b1, 8'h10, 1'b1},
      '{1'b0, 8'hFF, 1'b1, 8'h20, 1'b1},
      '{1'b0, 8'hFF, 1'b1, 8'h40, 1'b1},
      '{1'b0, 8'hFF, 1'b1, 8'h80, 1'b1},
      '{1'b0, 8'hFF, 1'b1, 8'h01, 1'b1},
      '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1},
      '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0},
      '{1'b0, 8'h20, 1'b1, 8'h20, 1'b0},
      '{1'b0, 8'h03, 1'b1, 8'h01, 1'b1},
      '{1'b0, 8'h03, 1'b1, 8'h02, 1'b1},
      '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1},
      '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0},
      '{1'b0, 8'h30, 1'b0, 8'h10, 1'b0},
      '{1'b0, 8'h30, 1'b0, 8'h00, 1'b1},
      '{1'b0, 8'h30, 1'b0, 8'h00, 1'b1},
      '{1'b0, 8'h30, 1'b0, 8'h00, 1'b1},
      '{1'b0, 8'h30, 1'b1, 8'h20, 1'b1},
      '{1'b0, 8'h00, 1'b1, 8'h00, 1'b1},
      '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0}
    };
    for (int i = 0; i < 8; i++) din[i*8 +: 8] = 8'h10 + 8'(i);
    rst        = 1'b1;
    req        = 8'hFF;
    dout_ready = 1'b1;
`ifdef MUX8_SCHED_PRIO_EN
    hi_prio    = 8'h00;
`endif
    @(posedge clk);

    for (int i = 0; i < 24; i++) apply(tbl[i]);

    // single requester with a distinctive word
    din[3*8 +: 8] = 8'hA5;
    apply('{1'b0, 8'h08, 1'b1, 8'h08, 1'b0});
    apply('{1'b0, 8'h00, 1'b1, 8'h00, 1'b1});
    apply('{1'b0, 8'h00, 1'b1, 8'h00, 1'b0});

    // backpressure holding 8'h42
    din[0 +: 8] = 8'h42;
    apply('{1'b0, 8'h01, 1'b1, 8'h01, 1'b0});
    repeat (5) apply('{1'b0, 8'h30, 1'b0, 8'h00, 1'b1});
    apply('{1'b0, 8'h30, 1'b1, 8'h10, 1'b1});
    apply('{1'b0, 8'h00, 1'b1, 8'h00, 1'b1});
    apply('{1'b0, 8'h00, 1'b1, 8'h00, 1'b0});

    // reset while a word is stalled
    apply('{1'b0, 8'h01, 1'b0, 8'h01, 1'b0});
    apply('{1'b1, 8'hFF, 1'b0, 8'h00, 1'b1});
    apply('{1'b0, 8'hFF, 1'b1, 8'h01, 1'b0});
    apply('{1'b0, 8'h00, 1'b1, 8'h00, 1'b1});
    apply('{1'b0, 8'h00, 1'b1, 8'h00, 1'b0});

`ifdef MUX8_SCHED_PRIO_EN
    hi_prio = 8'h84;
    apply('{1'b0, 8'hFF, 1'b1, 8'h04, 1'b0});
    apply('{1'b0, 8'hFF, 1'b1, 8'h80, 1'b1});
    apply('{1'b0, 8'hFF, 1'b1, 8'h04, 1'b1});
    apply('{1'b0, 8'hFF, 1'b1, 8'h80, 1'b1});
    apply('{1'b0, 8'h00, 1'b1, 8'h00, 1'b1});
    apply('{1'b0, 8'h00, 1'b1, 8'h00, 1'b0});
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
